// File: rtl/stream_packer_pkg.sv
// Shared constants and state encoding for the stream packer.
// Imported by the interface and the top module.
package stream_packer_pkg;

   localparam int WIDTH_DEFAULT = 8;
   localparam int LANES_DEFAULT = 4;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      EMIT = 1'b1
   } state_e;

   function automatic int count_width(input int lanes);
      return $clog2(lanes + 1);
   endfunction

endpackage

// File: rtl/stream_packer_if.sv
// Narrow valid/yumi input side and wide valid/ready output side of the packer.
// The slave modport is the packer's view; master is the environment's view.
interface stream_packer_if
   import stream_packer_pkg::*;
#(
   parameter int width_p = WIDTH_DEFAULT,
   parameter int lanes_p = LANES_DEFAULT
) ();

   localparam int count_w_lp = count_width(lanes_p);

   logic                       valid_i;
   logic [width_p-1:0]         data_i;
   logic                       yumi_o;
   logic                       flush_i;
   logic                       valid_o;
   logic [width_p*lanes_p-1:0] data_o;
   logic                       ready_i;
   logic [count_w_lp-1:0]      count_o;

   modport slave (
      input  valid_i, data_i, flush_i, ready_i,
      output yumi_o, valid_o, data_o, count_o
   );

   modport master (
      output valid_i, data_i, flush_i, ready_i,
      input  yumi_o, valid_o, data_o, count_o
   );

endinterface

// File: rtl/stream_packer.sv
// Pops narrow words from a FIFO and packs lanes_p of them into one wide word,
// lane 0 in the LSBs; flush emits a zero-padded partial word.
module stream_packer
   import stream_packer_pkg::*;
#(
   parameter int width_p = WIDTH_DEFAULT,
   parameter int lanes_p = LANES_DEFAULT
) (
   input  logic            clk_i,
   input  logic            reset_i,
   stream_packer_if.slave  bus
);

   localparam int count_w_lp = count_width(lanes_p);
   localparam logic [count_w_lp-1:0] last_lp = count_w_lp'(lanes_p - 1);

   state_e                            state_q, state_d;
   logic [count_w_lp-1:0]             count_q, count_d;
   logic [lanes_p-1:0][width_p-1:0]   lanes_q, lanes_d;

   logic                  valid_s;
   logic                  yumi_s;
   logic                  clear_s;
   logic [count_w_lp-1:0] wr_idx_s;
   logic [lanes_p-1:0]    wr_en_s;

   assign valid_s = (state_q == EMIT);
   // Reset gates the pop so the FIFO never loses a word while we are held in reset.
   assign yumi_s  = reset_i & bus.valid_i & (~valid_s | bus.ready_i);

   assign bus.yumi_o  = yumi_s;
   assign bus.valid_o = valid_s;
   assign bus.data_o  = lanes_q;
   assign bus.count_o = count_q;

   // A pop during the output handshake always lands in lane 0 of the fresh buffer.
   assign wr_idx_s = valid_s ? '0 : count_q;

   // Lane write-enable decode.
   always_comb begin
      wr_en_s = '0;
      for (int k = 0; k < lanes_p; k++) begin
         if (yumi_s && (wr_idx_s == count_w_lp'(k))) begin
            wr_en_s[k] = 1'b1;
         end else begin
            wr_en_s[k] = 1'b0;
         end
      end
   end

   // Next state, fill count and buffer clear.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      clear_s = 1'b0;
      case (state_q)
         FILL: begin
            if (yumi_s && (count_q == last_lp)) begin
               state_d = EMIT;
               count_d = '0;
            end else if (yumi_s && bus.flush_i) begin
               state_d = EMIT;
               count_d = '0;
            end else if (yumi_s) begin
               state_d = FILL;
               count_d = count_q + count_w_lp'(1);
            end else if (bus.flush_i && (count_q != '0)) begin
               state_d = EMIT;
               count_d = '0;
            end else begin
               state_d = FILL;
               count_d = count_q;
            end
         end
         EMIT: begin
            if (bus.ready_i) begin
               state_d = FILL;
               clear_s = 1'b1;
               count_d = yumi_s ? count_w_lp'(1) : '0;
            end else begin
               state_d = EMIT;
               count_d = count_q;
            end
         end
         default: begin
            state_d = FILL;
            count_d = '0;
         end
      endcase
   end

   // Lane buffer update: write wins over clear so a same-edge pop survives the handshake.
   always_comb begin
      lanes_d = lanes_q;
      for (int k = 0; k < lanes_p; k++) begin
         if (wr_en_s[k]) begin
            lanes_d[k] = bus.data_i;
         end else if (clear_s) begin
            lanes_d[k] = '0;
         end else begin
            lanes_d[k] = lanes_q[k];
         end
      end
   end

   // State, count and lane registers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= FILL;
         count_q <= '0;
         lanes_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lanes_q <= lanes_d;
      end
   end

endmodule

// File: tb/tb_stream_packer.sv
// Directed self-checking bench for stream_packer with width_p=8, lanes_p=4.
module tb_stream_packer;

   logic clk_i = 1'b0;
   logic reset_i = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk_i = ~clk_i;

   stream_packer_if #(.width_p(8), .lanes_p(4)) bus ();

   stream_packer #(.width_p(8), .lanes_p(4)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      bus.valid_i = 1'b1;
      bus.data_i  = 8'h11;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b1;
      #2;
      chk("rst_valid", 64'(bus.valid_o), 64'd0);
      chk("rst_count", 64'(bus.count_o), 64'd0);
      chk("rst_data",  64'(bus.data_o),  64'd0);
      chk("rst_yumi",  64'(bus.yumi_o),  64'd0);
      step();
      reset_i = 1'b1;

      // Test 1: four words 0x11..0x44
      for (int i = 1; i <= 4; i++) begin
         bus.data_i = 8'(i * 8'h11);
         #1;
         chk("t1_yumi", 64'(bus.yumi_o), 64'd1);
         step();
         chk("t1_count", 64'(bus.count_o), 64'(i % 4));
      end
      bus.valid_i = 1'b0;
      #1;
      chk("t1_valid", 64'(bus.valid_o), 64'd1);
      chk("t1_data",  64'(bus.data_o),  64'h44332211);
      chk("t1_yumi_novalid", 64'(bus.yumi_o), 64'd0);
      step();
      chk("t1_drain", 64'(bus.valid_o), 64'd0);

      // Test 2: back-to-back 8 words, no bubble
      for (int i = 1; i <= 8; i++) begin
         bus.valid_i = 1'b1;
         bus.data_i  = 8'(i);
         #1;
         chk("t2_yumi", 64'(bus.yumi_o), 64'd1);
         if (i == 5) begin
            chk("t2_valid0", 64'(bus.valid_o), 64'd1);
            chk("t2_data0",  64'(bus.data_o),  64'h04030201);
         end
         step();
      end
      bus.valid_i = 1'b0;
      chk("t2_valid1", 64'(bus.valid_o), 64'd1);
      chk("t2_data1",  64'(bus.data_o),  64'h08070605);
      chk("t2_count",  64'(bus.count_o), 64'd0);
      step();
      chk("t2_drain", 64'(bus.valid_o), 64'd0);

      // Test 3: backpressure for 5 cycles
      for (int i = 1; i <= 4; i++) begin
         bus.valid_i = 1'b1;
         bus.data_i  = 8'(8'hA0 + i);
         step();
      end
      bus.ready_i = 1'b0;
      bus.data_i  = 8'hB1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_yumi_hold",  64'(bus.yumi_o),  64'd0);
         chk("t3_valid_hold", 64'(bus.valid_o), 64'd1);
         chk("t3_data_hold",  64'(bus.data_o),  64'hA4A3A2A1);
         step();
      end
      bus.ready_i = 1'b1;
      #1;
      chk("t3_yumi_release", 64'(bus.yumi_o), 64'd1);
      step();
      bus.valid_i = 1'b0;
      chk("t3_valid_after", 64'(bus.valid_o), 64'd0);
      chk("t3_count_after", 64'(bus.count_o), 64'd1);
      chk("t3_data_after",  64'(bus.data_o),  64'h000000B1);
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      chk("t3_flush_data", 64'(bus.data_o), 64'h000000B1);
      step();

      // Test 4: two pops then flush with no pop
      bus.valid_i = 1'b1;
      bus.data_i  = 8'hAA;
      step();
      bus.data_i  = 8'hBB;
      step();
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      chk("t4_valid", 64'(bus.valid_o), 64'd1);
      chk("t4_data",  64'(bus.data_o),  64'h0000BBAA);
      chk("t4_count", 64'(bus.count_o), 64'd0);
      step();

      // Test 5: empty flush ignored; flush coinciding with a pop
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      chk("t5_empty_valid", 64'(bus.valid_o), 64'd0);
      chk("t5_empty_count", 64'(bus.count_o), 64'd0);
      bus.valid_i = 1'b1;
      bus.data_i  = 8'hAA;
      step();
      bus.data_i  = 8'hCC;
      bus.flush_i = 1'b1;
      #1;
      chk("t5_yumi_flush", 64'(bus.yumi_o), 64'd1);
      step();
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      chk("t5_valid", 64'(bus.valid_o), 64'd1);
      chk("t5_data",  64'(bus.data_o),  64'h0000CCAA);
      chk("t5_count", 64'(bus.count_o), 64'd0);
      step();

      // Test 6: asynchronous reset mid-fill
      bus.valid_i = 1'b1;
      bus.data_i  = 8'h55;
      step();
      bus.data_i  = 8'h66;
      step();
      chk("t6_count_pre", 64'(bus.count_o), 64'd2);
      bus.data_i = 8'h77;
      reset_i    = 1'b0;
      #1;
      chk("t6_valid_rst", 64'(bus.valid_o), 64'd0);
      chk("t6_count_rst", 64'(bus.count_o), 64'd0);
      chk("t6_yumi_rst",  64'(bus.yumi_o),  64'd0);
      chk("t6_data_rst",  64'(bus.data_o),  64'd0);
      step();
      reset_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         bus.data_i = 8'(8'h90 + i);
         #1;
         chk("t6_yumi", 64'(bus.yumi_o), 64'd1);
         step();
      end
      bus.valid_i = 1'b0;
      chk("t6_valid", 64'(bus.valid_o), 64'd1);
      chk("t6_data",  64'(bus.data_o),  64'h94939291);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
- Drain-side companion to the team's FIFO. It pops narrow words from a FIFO's valid/yumi producer interface and packs lanes_p consecutive words into one wide word.
- The wide word is presented on a valid/ready interface, e.g. a full systolic-array row or column vector.
- It supports an explicit flush that emits a partially filled, zero-padded word at the end of a stream.

Parameters:
- width_p, 8: bits per narrow input word.
- lanes_p, 4: narrow words per wide output word; must be ≥2.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- reset_i  input  1  asynchronous, active-low reset (0 = reset asserted).
- valid_i  input  1  upstream FIFO has a word (connects to FIFO valid_o).
- data_i  input  width_p  upstream word (connects to FIFO data_o).
- yumi_o  output  1  word consumed this cycle (connects to FIFO yumi_i).
- flush_i  input  1  request emission of the current partial word.
- valid_o  output  1  wide word available.
- data_o  output  width_p*lanes_p  packed word; lane k occupies bits [k*width_p +: width_p].
- ready_i  input  1  downstream accepts the wide word.
- count_o  output  $clog2(lanes_p+1)  lanes currently filled and not yet emitted.

Behaviour:
Reset and handshake:
- While reset_i=0: valid_o=0, count_o=0, data_o=0, yumi_o=0. yumi_o is forced low combinationally during reset.
- Reset takes effect immediately, even mid-word; any partial word is discarded.
- Output handshake completes when valid_o & ready_i.
- yumi_o = reset_i & valid_i & (~valid_o | ready_i). It is combinational, never asserted without valid_i, and never depends on flush_i.

Lane fill and emit:
- On yumi_o, data_i is written to lane count and count increments.
- The first word popped lands in lane 0, i.e. the LSBs of data_o.
- When the lanes_p-th word is popped: count wraps to 0 and valid_o rises the next cycle. Latency is 1 cycle from the last yumi_o to valid_o.
- While valid_o=1, data_o and valid_o hold stable until ready_i.
- Simultaneous output handshake and yumi_o: the handshake completes and the new word is written to lane 0 of a freshly cleared buffer in the same edge. There is no bubble, so sustained throughput is one narrow word per cycle.
- After a handshake, unfilled lanes read as 0.

Flush:
- If flush_i=1, valid_o=0 and (count>0 or yumi_o) at the edge:
  - any word popped that cycle is included;
  - valid_o rises the next cycle, with lanes at or above the filled count set to 0;
  - count returns to 0.
- flush_i with count=0 and no pop: ignored.
- flush_i while valid_o=1: ignored. The caller must hold it until valid_o=0.
- Flush coinciding with the lanes_p-th pop behaves identically to a normal fill.

Backpressure and invariants:
- ready_i=0 with valid_o=1: yumi_o=0, and the FIFO retains its data.
- count_o is never equal to lanes_p at a register boundary.
- No combinational path from ready_i to valid_o. The only ready_i→yumi_o path is a single AND.

State machine, 2 states:
- FILL: valid_o=0.
  - Goes to EMIT on the lanes_p-th pop or on an accepted flush; otherwise stays.
- EMIT: valid_o=1.
  - ready_i=1 → FILL, with the simultaneous pop handled as above.
  - ready_i=0 → stays in EMIT.

Decomposition:
- Shared systolic_pkg: default width and lanes constants; the state enum typedef {FILL, EMIT}.
- Lane write-enable decode stays in the block.
- No sub-module is needed. The lane buffer is an array register inside stream_packer.

Test Plan (width_p=8, lanes_p=4):
1. Reset release, FIFO holds 0x11,0x22,0x33,0x44, ready_i=1 → yumi_o high 4 cycles; valid_o=1 the cycle after, data_o=0x44332211; count_o 1,2,3,0.
2. Continuous 8-word stream 0x01..0x08, ready_i=1 → two outputs 0x04030201, 0x08070605; yumi_o high 8 consecutive cycles, no bubble.
3. Full word held with ready_i=0 for 5 cycles while valid_i=1 → yumi_o=0 and data_o stable throughout; on ready_i=1, yumi_o=1 that same cycle and the next word starts in lane 0.
4. Pop 0xAA,0xBB, then flush_i=1 with valid_i=0 → valid_o next cycle, data_o=0x0000BBAA, count_o=0.
5. flush_i with count=0 and valid_i=0 → no valid_o. Separately, flush_i on the same cycle as a pop of 0xCC at count=1 after 0xAA → data_o=0x0000CCAA.
6. reset_i driven low mid-fill at count=2 → valid_o, count_o and yumi_o go 0 immediately; after release, the next 4 words pack from lane 0.
